// File: rtl/median_window_3x3_if.sv
// Pixel-in / window-out bundle for the 3x3 neighbourhood generator.
// The slave modport is the generator; the master drives pixels and observes windows.
interface median_window_3x3_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned X_WIDTH    = 10,
    parameter int unsigned Y_WIDTH    = 9
);
    logic                    inValid;
    logic                    inSof;
    logic [DATA_WIDTH-1:0]   inData;
    logic                    outValid;
    logic [9*DATA_WIDTH-1:0] outWindow;
    logic [X_WIDTH-1:0]      outX;
    logic [Y_WIDTH-1:0]      outY;

    modport master (
        output inValid, inSof, inData,
        input  outValid, outWindow, outX, outY
    );

    modport slave (
        input  inValid, inSof, inData,
        output outValid, outWindow, outX, outY
    );
endinterface

// File: rtl/median_window_3x3.sv
// Streaming 3x3 window generator: two cascaded line buffers plus a 3-column shift window.
// Pipeline: accept/read (edge n), column shift (n+1), output register (n+2).
module median_window_3x3 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned X_WIDTH    = 10,
    parameter int unsigned Y_WIDTH    = 9
) (
    input logic                clk,
    input logic                rst,
    median_window_3x3_if.slave bus_io
);
    localparam logic [X_WIDTH-1:0] XLast = X_WIDTH'(IMG_WIDTH - 1);
    localparam logic [Y_WIDTH-1:0] YLast = Y_WIDTH'(IMG_HEIGHT - 1);

    typedef logic [DATA_WIDTH-1:0] pix_t;

    logic               accept;
    logic [X_WIDTH-1:0] x_q, x_d, px;
    logic [Y_WIDTH-1:0] y_q, y_d, py;

    always_comb begin
        accept = bus_io.inValid && !rst;
        px     = bus_io.inSof ? '0 : x_q;
        py     = bus_io.inSof ? '0 : y_q;
        x_d    = x_q;
        y_d    = y_q;
        if (accept) begin
            if (px == XLast) begin
                x_d = '0;
                y_d = (py == YLast) ? '0 : py + Y_WIDTH'(1);
            end else begin
                x_d = px + X_WIDTH'(1);
                y_d = py;
            end
        end
    end

    // Line buffers are never reset; B is fed from A's old value so it lags one more line.
    pix_t line_a_q [IMG_WIDTH];
    pix_t line_b_q [IMG_WIDTH];
    pix_t rd_a_q, rd_b_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_a_q       <= line_a_q[px];
            rd_b_q       <= line_b_q[px];
            line_a_q[px] <= bus_io.inData;
            line_b_q[px] <= line_a_q[px];
        end
    end

    logic               s1_valid_q;
    pix_t               s1_pix_q;
    logic [X_WIDTH-1:0] s1_x_q;
    logic [Y_WIDTH-1:0] s1_y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            s1_valid_q <= accept;
            if (accept) begin
                s1_pix_q <= bus_io.inData;
                s1_x_q   <= px;
                s1_y_q   <= py;
            end
        end
    end

    // col_q[col][row]; column 2 is the newest.
    pix_t               col_q [3][3];
    logic               s2_valid_q;
    logic [X_WIDTH-1:0] s2_x_q;
    logic [Y_WIDTH-1:0] s2_y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    col_q[c][r] <= '0;
                end
            end
            s2_valid_q <= 1'b0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
        end else begin
            s2_valid_q <= s1_valid_q && (s1_x_q >= X_WIDTH'(2)) && (s1_y_q >= Y_WIDTH'(2));
            if (s1_valid_q) begin
                for (int r = 0; r < 3; r++) begin
                    col_q[0][r] <= col_q[1][r];
                    col_q[1][r] <= col_q[2][r];
                end
                col_q[2][0] <= rd_b_q;
                col_q[2][1] <= rd_a_q;
                col_q[2][2] <= s1_pix_q;
                s2_x_q      <= s1_x_q - X_WIDTH'(1);
                s2_y_q      <= s1_y_q - Y_WIDTH'(1);
            end
        end
    end

    logic [9*DATA_WIDTH-1:0] win;

    always_comb begin
        win = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win[(r*3+c)*DATA_WIDTH +: DATA_WIDTH] = col_q[c][r];
            end
        end
    end

    logic                    out_valid_q;
    logic [9*DATA_WIDTH-1:0] out_window_q;
    logic [X_WIDTH-1:0]      out_x_q;
    logic [Y_WIDTH-1:0]      out_y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_window_q <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
        end else begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_window_q <= win;
                out_x_q      <= s2_x_q;
                out_y_q      <= s2_y_q;
            end
        end
    end

    assign bus_io.outValid  = out_valid_q;
    assign bus_io.outWindow = out_window_q;
    assign bus_io.outX      = out_x_q;
    assign bus_io.outY      = out_y_q;
endmodule

// File: tb/tb_median_window_3x3.sv
// Randomised and directed bench for median_window_3x3 on a 4x4 image, checked against
// a frame-array reference model with a due-cycle queue of expected windows.
module tb_median_window_3x3;
    localparam int W = 4;
    localparam int H = 4;

    logic clk;
    logic rst;

    median_window_3x3_if #(.DATA_WIDTH(8), .X_WIDTH(2), .Y_WIDTH(2)) bus ();

    median_window_3x3 #(
        .DATA_WIDTH(8),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .X_WIDTH   (2),
        .Y_WIDTH   (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [71:0] win;
        logic [1:0]  x;
        logic [1:0]  y;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  img [H][W];
    int          mx, my, cyc;
    int          n_checks, n_errors, pulses;
    logic [71:0] last_win, first_obs, last_obs;
    logic [1:0]  last_x, last_y;

    task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_edge(input logic v, input logic s, input logic [7:0] d, input logic r);
        int   px, py;
        exp_t e;
        if (r) begin
            exp_q.delete();
            mx = 0; my = 0;
            last_win = '0; last_x = '0; last_y = '0;
        end else if (v) begin
            px = s ? 0 : mx;
            py = s ? 0 : my;
            img[py][px] = d;
            if (px >= 2 && py >= 2) begin
                e.due = cyc + 2;
                e.x   = 2'(px - 1);
                e.y   = 2'(py - 1);
                e.win = '0;
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        e.win[(rr*3+cc)*8 +: 8] = img[py-2+rr][px-2+cc];
                exp_q.push_back(e);
            end
            if (px == W - 1) begin
                mx = 0;
                my = (py == H - 1) ? 0 : py + 1;
            end else begin
                mx = px + 1;
                my = py;
            end
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (bus.outValid === 1'b1) begin
            if (pulses == 0) first_obs = bus.outWindow;
            last_obs = bus.outWindow;
            pulses++;
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check_eq("valid", 72'(bus.outValid), 72'(1'b1));
            check_eq("window", bus.outWindow, e.win);
            check_eq("outX", 72'(bus.outX), 72'(e.x));
            check_eq("outY", 72'(bus.outY), 72'(e.y));
            last_win = e.win; last_x = e.x; last_y = e.y;
        end else begin
            check_eq("idle_valid", 72'(bus.outValid), 72'(1'b0));
            check_eq("hold_window", bus.outWindow, last_win);
            check_eq("hold_xy", 72'({bus.outX, bus.outY}), 72'({last_x, last_y}));
        end
    endtask

    task automatic cycle(input logic v, input logic s, input logic [7:0] d, input logic r);
        bus.inValid = v;
        bus.inSof   = s;
        bus.inData  = d;
        rst         = r;
        @(posedge clk);
        cyc++;
        model_edge(v, s, d, r);
        @(negedge clk);
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        logic       v, s, r;
        n_checks = 0; n_errors = 0; cyc = 0; pulses = 0;
        mx = 0; my = 0;
        last_win = '0; last_x = '0; last_y = '0;
        first_obs = '0; last_obs = '0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) img[yy][xx] = '0;
        bus.inValid = 1'b0; bus.inSof = 1'b0; bus.inData = '0; rst = 1'b1;
        @(negedge clk);

        // Reset, with inValid high to show reset wins.
        cycle(1'b1, 1'b0, 8'h5a, 1'b1);
        cycle(1'b1, 1'b0, 8'h5a, 1'b1);
        check_eq("rst_window", bus.outWindow, 72'h0);
        idle(2);

        // Continuous frame.
        pulses = 0;
        for (int i = 0; i < 16; i++) cycle(1'b1, i == 0, 8'(16 * (i / 4) + i % 4), 1'b0);
        idle(3);
        check_eq("cont_pulses", 72'(pulses), 72'd4);
        check_eq("cont_first", first_obs, 72'h22_21_20_12_11_10_02_01_00);
        check_eq("cont_last", last_obs, 72'h33_32_31_23_22_21_13_12_11);

        // Gapped frame.
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, i == 0, 8'(16 * (i / 4) + i % 4), 1'b0);
            cycle(1'b0, 1'b0, 8'hee, 1'b0);
        end
        idle(3);
        check_eq("gap_pulses", 72'(pulses), 72'd4);
        check_eq("gap_last", last_obs, 72'h33_32_31_23_22_21_13_12_11);

        // Mid-frame inSof at (3,1), then a full frame from the restart.
        pulses = 0;
        for (int i = 0; i < 23; i++) cycle(1'b1, (i == 0) || (i == 7), 8'($urandom), 1'b0);
        idle(3);
        check_eq("sof_pulses", 72'(pulses), 72'd4);

        // Reset while pixel (2,2) is in flight.
        for (int i = 0; i < 11; i++) cycle(1'b1, i == 0, 8'(16 * (i / 4) + i % 4), 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        pulses = 0;
        for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 8'(8'h80 + 16 * (i / 4) + i % 4), 1'b0);
        idle(3);
        check_eq("rst_flight_pulses", 72'(pulses), 72'd1);
        check_eq("rst_flight_win", last_obs, 72'ha2_a1_a0_92_91_90_82_81_80);

        // Two frames back to back, inSof only on the first.
        pulses = 0;
        for (int i = 0; i < 32; i++)
            cycle(1'b1, i == 0, 8'(16 * ((i % 16) / 4) + i % 4 + ((i >= 16) ? 8'h40 : 8'h00)), 1'b0);
        idle(3);
        check_eq("two_frame_pulses", 72'(pulses), 72'd8);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) < 7);
            s = v && ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 149) == 0);
            d = 8'($urandom);
            cycle(v, s, d, r);
        end
        idle(3);
        check_eq("queue_drained", 72'(exp_q.size()), 72'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
